// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-serial load/store engine between a CPU-side request
// and a byte-wide data memory. Multi-byte accesses are big-endian and walk
// addr, addr+1, ... one byte per cycle.
// Optional build macro: MISALIGN_CHECK_EN -- reject misaligned halfword/word
// accesses in one cycle with err raised during done.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  output logic              m_we,
  output logic              m_re,
  input  logic [7:0]        m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_n;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [31:0]       wdata_q;
  logic [1:0]        cnt;
  logic [23:0]       acc;

  logic [1:0]        last;
  logic [1:0]        sel;
  logic [31:0]       ld_full;
  logic [31:0]       ld_val;
  logic              misalign;

  // Index of the final byte (N-1) for the captured access size
  always_comb begin
    last = 2'd3;
    case (size_q)
      2'b00:   last = 2'd0;
      2'b01:   last = 2'd1;
      default: last = 2'd3;
    endcase
  end

  // Misalignment detection on the incoming request
`ifdef MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr[0];
      default: misalign = |addr[1:0];
    endcase
  end
`else
  always_comb misalign = 1'b0;
`endif

  // Load assembly: accumulated bytes plus the byte on the bus this cycle,
  // then zero/sign extension by captured size
  always_comb begin
    ld_full = {acc, m_rdata};
    ld_val  = ld_full;
    case (size_q)
      2'b00:   ld_val = sext_q ? {{24{ld_full[7]}}, ld_full[7:0]}
                               : {24'h0, ld_full[7:0]};
      2'b01:   ld_val = sext_q ? {{16{ld_full[15]}}, ld_full[15:0]}
                               : {16'h0, ld_full[15:0]};
      default: ld_val = ld_full;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req) state_n = misalign ? DONE : XFER;
      XFER:    if (cnt == last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Memory-side strobes and status outputs, all derived from the state so
  // reset clears them asynchronously
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    m_we    = 1'b0;
    m_re    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    sel     = last - cnt;
    if (state == XFER) begin
      m_we   = we_q;
      m_re   = ~we_q;
      m_addr = addr_q + ADDR_W'(cnt);
      if (we_q) m_wdata = wdata_q[{sel, 3'b000} +: 8];
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic err_q;

  // Misalignment flag captured at acceptance, presented only while done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err_q <= 1'b0;
    else if (state == IDLE && req)   err_q <= misalign;
  end

  // Gate the flag with done so it is only visible during completion
  always_comb err = done & err_q;
`else
  // Misaligned accesses run byte-wise, so there is never an error
  always_comb err = 1'b0;
`endif

  // Request capture, byte counter, load accumulator and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      cnt     <= '0;
      acc     <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            wdata_q <= wdata;
            cnt     <= '0;
            acc     <= '0;
          end
        end
        XFER: begin
          cnt <= cnt + 2'd1;
          if (!we_q) begin
            acc <= ld_full[23:0];
            if (cnt == last) rdata <= ld_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a reference model computes expected
// strobes and completions per request; a negedge monitor checks them.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = '0;
  logic          sign_ext = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic          busy, done, err, m_we, m_re;
  logic [31:0]   rdata;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata, m_rdata;

  mem_access_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .rdata(rdata), .err(err), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // 256-byte memory, address bits above 7 alias
  logic [7:0] mem  [256];
  logic [7:0] refm [256];
  assign m_rdata = mem[m_addr[7:0]];
  always @(posedge clk) if (m_we) mem[m_addr[7:0]] <= m_wdata;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed { logic w; logic [31:0] a; logic [7:0] d; } strb_t;
  typedef struct packed { logic [31:0] rd; logic e; logic [31:0] c; } done_t;
  strb_t sq[$];
  done_t dq[$];
  strb_t s;
  done_t d;
  logic [31:0] mrd = '0;

  // Reference: applies the access to refm and queues expected bus activity
  task automatic model(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    int unsigned n;
    logic mis;
    logic [31:0] v, ad;
    logic [7:0] b;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
    if (mis) begin
      dq.push_back('{mrd, 1'b1, cyc + 1});
    end else begin
      v = '0;
      for (int unsigned k = 0; k < n; k++) begin
        ad = a + k;
        if (w) begin
          b = 8'(wd >> (8 * (n - 1 - k)));
          refm[ad[7:0]] = b;
          sq.push_back('{1'b1, ad, b});
        end else begin
          sq.push_back('{1'b0, ad, 8'h00});
          v = (v << 8) | 32'(refm[ad[7:0]]);
        end
      end
      if (!w) begin
        if (sx && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sx && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        mrd = v;
      end
      dq.push_back('{mrd, 1'b0, cyc + n + 1});
    end
  endtask

  // Issue one request from an IDLE-cycle negedge; scramble inputs while busy;
  // return at the negedge of the following IDLE cycle
  task automatic txn(input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd);
    int unsigned n;
    model(w, sz, sx, a, wd);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 20) begin
      req = 1'($urandom); we = 1'($urandom); size = 2'($urandom);
      sign_ext = 1'($urandom); addr = $urandom; wdata = $urandom;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk("done_timeout", 64'(done), 64'd1);
      sq.delete();
      dq.delete();
    end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, err, m_we, m_re}), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'd0);
    chk({tag, "_m_addr"}, 64'(m_addr), 64'd0);
    chk({tag, "_m_wdata"}, 64'(m_wdata), 64'd0);
  endtask

  // Monitor: compare every strobe and every completion against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_we || m_re) begin
        if (sq.size() == 0) begin
          chk("unexpected_strobe", 64'({m_we, m_re, m_addr}), 64'd0);
        end else begin
          s = sq.pop_front();
          chk("strobe_dir", 64'({m_we, m_re}), 64'({s.w, ~s.w}));
          chk("m_addr", 64'(m_addr), 64'(s.a));
          if (s.w) chk("m_wdata", 64'(m_wdata), 64'(s.d));
          chk("busy_xfer", 64'(busy), 64'd1);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          d = dq.pop_front();
          chk("rdata", 64'(rdata), 64'(d.rd));
          chk("err", 64'(err), 64'(d.e));
          chk("latency_cycle", 64'(cyc), 64'(d.c));
          chk("busy_done", 64'(busy), 64'd1);
          chk("strobes_drained", 64'(sq.size()), 64'd0);
        end
      end
    end
  end

  logic [31:0] wd;
  logic [31:0] ra;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  <= 8'(i);
      refm[i]  = 8'(i);
    end
    #12;
    chk_reset("reset0");
    @(negedge clk);
    rst_n = 1'b1;

    // LW 0x4, immediately after reset release
    txn(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("lw4_const", 64'(rdata), 64'h0405_0607);

    // LW 0x5 (misaligned word)
    txn(1'b0, 2'b10, 1'b0, 32'h5, 32'h0);
`ifdef MISALIGN_CHECK_EN
    chk("lw5_const", 64'(rdata), 64'h0405_0607);
`else
    chk("lw5_const", 64'(rdata), 64'h0506_0708);
`endif

    // LW wrapping past the top of the address space
    txn(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0);
`ifndef MISALIGN_CHECK_EN
    chk("lw_wrap_const", 64'(rdata), 64'hFEFF_0001);
`endif

    // SB then LB / LBU
    txn(1'b1, 2'b00, 1'b0, 32'h10, 32'hAABB_CC81);
    txn(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    chk("lb_const", 64'(rdata), 64'hFFFF_FF81);
    txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("lbu_const", 64'(rdata), 64'h0000_0081);

    // SH then LH
    txn(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000_BEEF);
    chk("sh_byte0", 64'(mem[8'h20]), 64'hBE);
    chk("sh_byte1", 64'(mem[8'h21]), 64'hEF);
    txn(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    chk("lh_const", 64'(rdata), 64'hFFFF_BEEF);

    // SW 0x8 aborted by reset after two bytes
    wd = $urandom;
    refm[8] = wd[31:24];
    refm[9] = wd[23:16];
    sq.push_back('{1'b1, 32'h8, wd[31:24]});
    sq.push_back('{1'b1, 32'h9, wd[23:16]});
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h8; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset("reset_xfer");
    sq.delete();
    dq.delete();
    mrd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_b8", 64'(mem[8]), 64'(wd[31:24]));
    chk("abort_b9", 64'(mem[9]), 64'(wd[23:16]));
    chk("abort_b10", 64'(mem[10]), 64'd10);
    chk("abort_b11", 64'(mem[11]), 64'd11);

    // Accepted at the first edge after reset release; size 11 as word
    txn(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);

    // Randomized mix of loads and stores
    for (int unsigned t = 0; t < 80; t++) begin
      ra = 32'h40 + 32'($urandom_range(0, 32'hB0));
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      txn(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom);
    end

    repeat (2) @(negedge clk);
    chk("sq_empty", 64'(sq.size()), 64'd0);
    chk("dq_empty", 64'(dq.size()), 64'd0);
    for (int i = 0; i < 256; i++)
      chk($sformatf("mem_final[%0d]", i), 64'(mem[i]), 64'(refm[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
